// File: rtl/spram_ctl.sv
// spram_ctl: valid/ready byte/half/word controller over a ROWS x (DW/16)-column SP256K-style array
// ports: clk/rst (sync, active-high); req_vld/req_rdy handshake with req_we, req_sz (0 b,1 h,2 w,3 err),
// req_sgn, req_a (byte address), req_d (right-aligned); registered response rsp_vld/rsp_err/rsp_d.
module spram_ctl #(
  parameter int DW = 32,
  parameter int ROWS = 2,
  localparam int NB = DW / 8,
  localparam int LB = $clog2(NB),
  localparam int WB = $clog2(ROWS * 16384),
  localparam int RB = (ROWS > 1) ? $clog2(ROWS) : 1,
  localparam int AW = WB + LB
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_vld,
  output logic          req_rdy,
  input  logic          req_we,
  input  logic [1:0]    req_sz,
  input  logic          req_sgn,
  input  logic [AW-1:0] req_a,
  input  logic [DW-1:0] req_d,
  output logic          rsp_vld,
  output logic          rsp_err,
  output logic [DW-1:0] rsp_d
);
  typedef enum logic [2:0] {IDLE, ACC0, ACC1, CAP, ERR} st_t;
  st_t st_q, st_d;
  logic [AW-1:0] a_q, a_d;
  logic we_q, we_d, sgn_q, sgn_d, rsp_vld_q, rsp_vld_d, rsp_err_q, rsp_err_d;
  logic [1:0] sz_q, sz_d;
  logic [DW-1:0] d_q, d_d, hold_q, hold_d, rsp_d_q, rsp_d_d;
  logic [RB-1:0] rsel_q, rsel_d, row;
  logic [WB-1:0] w, ad;
  logic [LB-1:0] l;
  logic [LB:0] nby;
  logic [NB-1:0] nbm, be;
  logic [2*NB-1:0] bm;
  logic [2*DW-1:0] wide_d, comb;
  logic [DW-1:0] szm, wdat, do_sel, v;
  logic [2*NB-1:0] mwe;
  logic [DW-1:0] dout [ROWS];
  logic [ROWS-1:0] cs;
  logic split, acc, we, sb;
  assign w = a_q[AW-1:LB];
  assign l = a_q[LB-1:0];
  assign nby = sz_q == 2'd0 ? (LB+1)'(1) : sz_q == 2'd1 ? (LB+1)'(2) : (LB+1)'(4);
  assign nbm = sz_q == 2'd0 ? NB'(1) : sz_q == 2'd1 ? NB'(3) : NB'(15);
  assign szm = sz_q == 2'd0 ? DW'(8'hFF) : sz_q == 2'd1 ? DW'(16'hFFFF) : DW'(32'hFFFF_FFFF);
  assign split = ({1'b0, l} + nby) > (LB+1)'(NB);
  // The access is laid out over a two-word window {w+1, w}; ACC0 drives the low half, ACC1 the high half.
  assign wide_d = {{DW{1'b0}}, d_q & szm} << {l, 3'b000};
  assign bm = {{NB{1'b0}}, nbm} << l;
  assign acc = st_q == ACC0 || st_q == ACC1;
  assign ad = st_q == ACC1 ? w + 1'b1 : w;
  assign row = RB'(ad >> 14);
  assign be = st_q == ACC1 ? bm[2*NB-1:NB] : bm[NB-1:0];
  assign wdat = st_q == ACC1 ? wide_d[2*DW-1:DW] : wide_d[DW-1:0];
  assign we = acc && we_q && !rst;
  assign do_sel = dout[rsel_q];
  assign comb = split ? {do_sel, hold_q} : {{DW{1'b0}}, do_sel};
  assign v = DW'(comb >> {l, 3'b000});
  assign sb = sz_q == 2'd0 ? v[7] : sz_q == 2'd1 ? v[15] : v[31];
  always_comb begin
    mwe = '0;
    for (int k = 0; k < NB; k++) mwe[2*k +: 2] = {2{be[k]}};
  end
  for (genvar r = 0; r < ROWS; r++) begin : g_row
    logic [DW-1:0] mem [16384];
    logic [DW-1:0] q;
    assign cs[r] = acc && row == RB'(r);
    always_ff @(posedge clk) begin
      if (cs[r]) begin
        if (we)
          for (int n = 0; n < 2*NB; n++)
            if (mwe[n]) mem[ad[13:0]][4*n +: 4] <= wdat[4*n +: 4];
        q <= mem[ad[13:0]];
      end
    end
    assign dout[r] = q;
  end
  always_comb begin
    st_d = st_q;
    a_d = a_q;
    we_d = we_q;
    sz_d = sz_q;
    sgn_d = sgn_q;
    d_d = d_q;
    hold_d = hold_q;
    rsel_d = acc ? row : rsel_q;
    rsp_vld_d = 1'b0;
    rsp_err_d = 1'b0;
    rsp_d_d = '0;
    case (st_q)
      IDLE: if (req_vld) begin
        a_d = req_a;
        we_d = req_we;
        sz_d = req_sz;
        sgn_d = req_sgn;
        d_d = req_d;
        st_d = req_sz == 2'd3 ? ERR : ACC0;
      end
      ACC0: begin
        st_d = split ? ACC1 : we_q ? IDLE : CAP;
        rsp_vld_d = !split && we_q;
      end
      ACC1: begin
        hold_d = do_sel;
        st_d = we_q ? IDLE : CAP;
        rsp_vld_d = we_q;
      end
      CAP: begin
        rsp_d_d = (v & szm) | ((sgn_q && sb) ? ~szm : '0);
        rsp_vld_d = 1'b1;
        st_d = IDLE;
      end
      default: begin
        rsp_vld_d = 1'b1;
        rsp_err_d = 1'b1;
        st_d = IDLE;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      st_q <= IDLE;
      rsp_vld_q <= 1'b0;
      rsp_err_q <= 1'b0;
      rsp_d_q <= '0;
    end else begin
      st_q <= st_d;
      rsp_vld_q <= rsp_vld_d;
      rsp_err_q <= rsp_err_d;
      rsp_d_q <= rsp_d_d;
    end
    a_q <= a_d;
    we_q <= we_d;
    sz_q <= sz_d;
    sgn_q <= sgn_d;
    d_q <= d_d;
    hold_q <= hold_d;
    rsel_q <= rsel_d;
  end
  assign req_rdy = st_q == IDLE;
  assign rsp_vld = rsp_vld_q;
  assign rsp_err = rsp_err_q;
  assign rsp_d = rsp_d_q;
endmodule

// File: tb/tb_spram_ctl.sv
// tb_spram_ctl: directed self-checking bench for spram_ctl at DW=32, ROWS=2
module tb_spram_ctl;
  logic clk = 1'b0, rst = 1'b1, req_vld = 1'b0, req_we = 1'b0, req_sgn = 1'b0;
  logic [1:0] req_sz = 2'd0;
  logic [16:0] req_a = '0;
  logic [31:0] req_d = '0;
  logic req_rdy, rsp_vld, rsp_err;
  logic [31:0] rsp_d;
  int n_chk = 0, n_fail = 0;
  int lat;
  logic [31:0] rd;
  logic err, seen;
  spram_ctl #(.DW(32), .ROWS(2)) dut (
    .clk(clk), .rst(rst), .req_vld(req_vld), .req_rdy(req_rdy), .req_we(req_we),
    .req_sz(req_sz), .req_sgn(req_sgn), .req_a(req_a), .req_d(req_d),
    .rsp_vld(rsp_vld), .rsp_err(rsp_err), .rsp_d(rsp_d)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask
  task automatic txn(input logic we, input logic [1:0] sz, input logic sgn, input logic [16:0] a,
                     input logic [31:0] d, output int l, output logic [31:0] r, output logic e);
    req_vld = 1'b1;
    req_we = we;
    req_sz = sz;
    req_sgn = sgn;
    req_a = a;
    req_d = d;
    @(posedge clk);
    #1;
    req_vld = 1'b0;
    l = 0;
    do begin
      @(posedge clk);
      #1;
      l++;
    end while (!rsp_vld && l < 10);
    r = rsp_d;
    e = rsp_err;
  endtask
  task automatic wr(input string tag, input logic [1:0] sz, input logic [16:0] a, input logic [31:0] d,
                    input int elat);
    txn(1'b1, sz, 1'b0, a, d, lat, rd, err);
    chk({tag, "_lat"}, 32'(lat), 32'(elat));
    chk({tag, "_d"}, {31'd0, err} | rd, 32'd0);
  endtask
  task automatic rdc(input string tag, input logic [1:0] sz, input logic sgn, input logic [16:0] a,
                     input logic [31:0] exp, input int elat);
    txn(1'b0, sz, sgn, a, 32'd0, lat, rd, err);
    chk({tag, "_lat"}, 32'(lat), 32'(elat));
    chk(tag, rd, exp);
  endtask
  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rdy", 32'(req_rdy), 32'd1);
    chk("rst_vld", {30'd0, rsp_vld, rsp_err}, 32'd0);
    chk("rst_d", rsp_d, 32'd0);
    rst = 1'b0;
    wr("w_word", 2'd2, 17'h10, 32'hDEADBEEF, 1);
    rdc("r_word", 2'd2, 1'b0, 17'h10, 32'hDEADBEEF, 2);
    wr("w_byte", 2'd0, 17'h13, 32'h123456A5, 1);
    rdc("r_byte_s", 2'd0, 1'b1, 17'h13, 32'hFFFFFFA5, 2);
    rdc("r_byte_u", 2'd0, 1'b0, 17'h13, 32'h000000A5, 2);
    rdc("r_word2", 2'd2, 1'b0, 17'h10, 32'hA5ADBEEF, 2);
    rdc("r_half_s", 2'd1, 1'b1, 17'h12, 32'hFFFFA5AD, 2);
    wr("w_split", 2'd2, 17'h0E, 32'h11223344, 2);
    rdc("r_b0e", 2'd0, 1'b0, 17'h0E, 32'h44, 2);
    rdc("r_b0f", 2'd0, 1'b0, 17'h0F, 32'h33, 2);
    rdc("r_b10", 2'd0, 1'b0, 17'h10, 32'h22, 2);
    rdc("r_b11", 2'd0, 1'b0, 17'h11, 32'h11, 2);
    rdc("r_split", 2'd2, 1'b0, 17'h0E, 32'h11223344, 3);
    rdc("r_half_split", 2'd1, 1'b1, 17'h0F, 32'h00002233, 3);
    wr("w_row0", 2'd2, 17'h0FFFC, 32'hAAAA5555, 1);
    wr("w_row1", 2'd2, 17'h10000, 32'h5555AAAA, 1);
    rdc("r_row0", 2'd2, 1'b0, 17'h0FFFC, 32'hAAAA5555, 2);
    rdc("r_row1", 2'd2, 1'b0, 17'h10000, 32'h5555AAAA, 2);
    rdc("r_row0b", 2'd2, 1'b0, 17'h0FFFC, 32'hAAAA5555, 2);
    rdc("r_row1b", 2'd2, 1'b0, 17'h10000, 32'h5555AAAA, 2);
    wr("w_wrap", 2'd2, 17'h1FFFE, 32'hCAFEF00D, 2);
    rdc("r_w0", 2'd0, 1'b0, 17'h1FFFE, 32'h0D, 2);
    rdc("r_w1", 2'd0, 1'b0, 17'h1FFFF, 32'hF0, 2);
    rdc("r_w2", 2'd0, 1'b0, 17'h00000, 32'hFE, 2);
    rdc("r_w3", 2'd0, 1'b0, 17'h00001, 32'hCA, 2);
    txn(1'b0, 2'd3, 1'b0, 17'h20, 32'hFFFFFFFF, lat, rd, err);
    chk("err_lat", 32'(lat), 32'd1);
    chk("err_flag", 32'(err), 32'd1);
    chk("err_d", rd, 32'd0);
    @(posedge clk);
    #1;
    chk("err_pulse", 32'(rsp_vld), 32'd0);
    wr("w_clr0", 2'd2, 17'h2C, 32'h0, 1);
    wr("w_clr1", 2'd2, 17'h30, 32'h0, 1);
    req_vld = 1'b1;
    req_we = 1'b1;
    req_sz = 2'd2;
    req_a = 17'h2E;
    req_d = 32'h55667788;
    @(posedge clk);
    #1;
    req_vld = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("abort_rdy", 32'(req_rdy), 32'd1);
    chk("abort_vld", 32'(rsp_vld), 32'd0);
    seen = 1'b0;
    repeat (5) begin
      @(posedge clk);
      #1;
      seen = seen | rsp_vld;
    end
    chk("abort_norsp", 32'(seen), 32'd0);
    rdc("abort_w", 2'd2, 1'b0, 17'h2C, 32'h77880000, 2);
    rdc("abort_w1", 2'd2, 1'b0, 17'h30, 32'h00000000, 2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
